status_register_unit: RTL
=========================

Name: status_register_unit

Overview:
- Holds the architectural NZCV status register and drives the 4-bit SR bus read by the condition-check logic in the ID stage.
- Shadows the S-bit of the instruction in the EXE stage. Raises a flag-hazard stall when a conditional instruction in ID would read flags that an in-flight EXE instruction has not yet committed.
- Sits between the EXE-stage ALU flag outputs and the ID-stage condition check.
- Obeys the global SRAM freeze and the branch flush.

Parameters:
- CNT_W, 16, width of the saturating hazard-stall counter
- AL_COND, 4'b1110, condition code for "always"; never stalls

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- freeze  input  1  SRAM stall; whole pipeline holds
- flush  input  1  branch taken; kills the instruction currently in ID
- id_valid  input  1  ID stage holds a real instruction
- id_s_bit  input  1  ID instruction updates flags
- id_cond  input  4  ID instruction condition field
- exe_flags  input  4  ALU flags {N,Z,C,V} of the instruction in EXE
- sr  output  4  architectural status {N,Z,C,V}: N=sr[3], Z=sr[2], C=sr[1], V=sr[0]
- flag_hazard  output  1  stall request to hazard unit (ID/IF hold, bubble into EXE)
- exe_s_pending  output  1  shadow bit: EXE holds a flag-setting instruction
- hazard_cnt  output  CNT_W  saturating count of cycles with flag_hazard=1

Behaviour:
- Reset (rst=0, asynchronous):
  - sr=4'b0000, exe_s_pending=0, hazard_cnt=0.
  - flag_hazard is therefore 0.
- flag_hazard is combinational:
  - flag_hazard = exe_s_pending & id_valid & ~flush & (id_cond != AL_COND).
  - It does not depend on freeze.
- Every rising edge with freeze=1:
  - sr, exe_s_pending and hazard_cnt all hold.
  - Freeze has priority over every other update, including flush.
- Rising edge with freeze=0, in priority order:
  1. SR commit: if exe_s_pending=1, then sr <= exe_flags. Otherwise sr holds.
  2. Shadow advance: exe_s_pending <= id_valid & id_s_bit & ~flush & ~flag_hazard.
     - A stalled or flushed ID instruction enters EXE as a bubble (0).
     - Only an issued instruction sets the shadow bit.
  3. Counter: if flag_hazard=1 and hazard_cnt != all-ones, hazard_cnt increments by 1. At all-ones it saturates and holds.
- Latency:
  - SR commits one cycle after the S instruction issues from ID (i.e. at the end of its EXE cycle).
  - The stall lasts exactly one unfrozen cycle per conflicting pair. The next cycle exe_s_pending=0 (a bubble was inserted), so the stalled instruction then issues and sees the updated sr.
- Back-to-back S instructions:
  - The second, if unconditional (AL), issues without stall.
  - Its shadow bit is set on the same edge that the first commits; no loss.
- A conditional S instruction behind an S instruction stalls one cycle, then issues with exe_s_pending set.
- An instruction with id_valid=0 never stalls and never sets the shadow bit.
- flush and hazard in the same cycle: flag_hazard=0 (the flushed instruction is not stalled). The bubble enters EXE; sr still commits from the EXE instruction.
- Reset mid-stall: all state clears immediately. flag_hazard drops in the same cycle, asynchronously via exe_s_pending.
- sr changes only on an unfrozen clock edge with exe_s_pending=1. There is no combinational bypass from exe_flags to sr.

Test Plan:
- Reset then idle:
  - Stimulus: rst low → high, id_valid=0 for 5 cycles.
  - Required: sr=0000, flag_hazard=0, hazard_cnt=0 throughout.
- Basic commit:
  - Stimulus: issue AL instruction with id_s_bit=1; next cycle exe_flags=4'b0100.
  - Required: exe_s_pending=1 for one cycle; sr=4'b0100 after the following edge; no stall.
- Flag hazard:
  - Stimulus: S instruction (AL) followed by EQ (id_cond=0000) instruction; exe_flags=0100.
  - Required: flag_hazard=1 for exactly one cycle; hazard_cnt=1; EQ instruction then issues with sr=0100.
- Freeze during hazard:
  - Stimulus: same as the hazard case, but freeze=1 for 3 cycles while flag_hazard=1.
  - Required: sr, exe_s_pending and hazard_cnt frozen; flag_hazard held at 1; after unfreeze, hazard_cnt=1 and sr updates once.
- Flush:
  - Stimulus: S instruction in EXE, conditional instruction in ID, with flush=1.
  - Required: flag_hazard=0; exe_s_pending=0 next cycle; sr still takes exe_flags.
- Saturation and async reset:
  - Stimulus: force a continuous hazard for 2^CNT_W+3 cycles (CNT_W=4 in bench), then drop rst mid-cycle.
  - Required: hazard_cnt holds at 4'hF; all outputs go to 0 before the next edge.

Source files
------------

// File: rtl/status_register_unit.sv
// status_register_unit
// Architectural NZCV status register with an EXE-stage S-bit shadow.
// Raises a one-cycle flag-hazard stall when a conditional instruction in ID
// would read flags that the instruction in EXE has not committed yet.
// Also keeps a saturating count of the cycles spent stalled on flags.

module status_register_unit #(
    parameter int          CNT_W   = 16,
    parameter logic [3:0]  AL_COND = 4'b1110
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_s_bit,
    input  logic [3:0]       id_cond,
    input  logic [3:0]       exe_flags,
    output logic [3:0]       sr,
    output logic             flag_hazard,
    output logic             exe_s_pending,
    output logic [CNT_W-1:0] hazard_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic id_conditional;
    logic id_issue_s;
    logic cnt_at_max;

    // The AL condition never reads flags, so it can never conflict.
    assign id_conditional = (id_cond != AL_COND);

    // Stall is independent of freeze; a flushed instruction is never stalled.
    assign flag_hazard = exe_s_pending & id_valid & ~flush & id_conditional;

    // Only an instruction that actually leaves ID carries its S-bit into EXE;
    // stalled or flushed slots become bubbles.
    assign id_issue_s = id_valid & id_s_bit & ~flush & ~flag_hazard;

    assign cnt_at_max = (hazard_cnt == CNT_MAX);

    // Commit the EXE flags at the end of the S instruction's EXE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= 4'b0000;
        end else if (!freeze && exe_s_pending) begin
            sr <= exe_flags;
        end
    end

    // Advance the S-bit shadow alongside the ID->EXE pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_s_pending <= 1'b0;
        end else if (!freeze) begin
            exe_s_pending <= id_issue_s;
        end
    end

    // Count unfrozen stall cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hazard_cnt <= '0;
        end else if (!freeze && flag_hazard && !cnt_at_max) begin
            hazard_cnt <= hazard_cnt + CNT_ONE;
        end
    end

endmodule
